fir_capture_reader: RTL and testbench

- Sink-side reader for the fir_filter output stream. It consumes the signed 16-bit filtered samples and, once armed, waits for an optional level trigger.
- After the trigger it captures DEPTH consecutive valid samples into an internal buffer and tracks their peak max and min.
- A host then drains the buffer in order over a valid/ready read port.
- It is the bring-up and verification observation point placed directly after the FIR datapath.

---
 rtl/fir_capture_reader.sv | 147 ++++++++++++++
 tb/tb_fir_capture_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_capture_reader.sv
// Capture/readout buffer placed after the FIR datapath: arm, optional level
// trigger, DEPTH-sample capture with signed peak tracking, then valid/ready drain.
module fir_capture_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_level,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   cap_count,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              done,
    output logic [DATA_W-1:0] peak_max,
    output logic [DATA_W-1:0] peak_min,
    output logic [7:0]        drop_cnt,
    output logic              arm_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    // Peaks start at the opposite extremes so the first stored sample wins both.
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    state_t            st, st_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_idx;
    logic              store, xfer, arm_ok, arm_bad, drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else      st <= st_nxt;
    end

    always_comb begin
        st_nxt  = st;
        store   = 1'b0;
        xfer    = 1'b0;
        arm_ok  = 1'b0;
        arm_bad = 1'b0;
        drop    = 1'b0;
        wr_idx  = wr_ptr;
        if (abort) begin
            st_nxt = IDLE;
        end else begin
            if (arm) begin
                if (st == IDLE) arm_ok  = 1'b1;
                else            arm_bad = 1'b1;
            end
            unique case (st)
                IDLE: begin
                    if (arm) st_nxt = ARMED;
                end
                ARMED: begin
                    if (sample_valid &&
                        (!trig_en || ($signed(sample_in) >= $signed(trig_level)))) begin
                        store  = 1'b1;
                        wr_idx = '0;
                        st_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        store = 1'b1;
                        if (cap_count == CNT_LAST) st_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    drop = sample_valid;
                    if (rd_ready) begin
                        xfer = 1'b1;
                        if (rd_ptr == PTR_LAST) st_nxt = IDLE;
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_idx] <= sample_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cap_count <= '0;
            done      <= 1'b0;
            arm_err   <= 1'b0;
            peak_max  <= '0;
            peak_min  <= '0;
            drop_cnt  <= '0;
        end else begin
            done <= xfer && rd_last;
            if (abort) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                cap_count <= '0;
            end else begin
                if (arm_bad) arm_err <= 1'b1;
                if (arm_ok) begin
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    cap_count <= '0;
                    drop_cnt  <= '0;
                    arm_err   <= 1'b0;
                    peak_max  <= MOST_NEG;
                    peak_min  <= MOST_POS;
                end
                if (store) begin
                    wr_ptr    <= (st_nxt == DRAIN) ? '0 : wr_idx + PTR_ONE;
                    cap_count <= cap_count + CNT_ONE;
                    if ($signed(sample_in) > $signed(peak_max)) peak_max <= sample_in;
                    if ($signed(sample_in) < $signed(peak_min)) peak_min <= sample_in;
                end
                if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 8'd1;
                if (xfer) rd_ptr <= rd_last ? '0 : rd_ptr + PTR_ONE;
            end
        end
    end

    assign state    = st;
    assign rd_valid = (st == DRAIN);
    assign rd_last  = rd_valid && (rd_ptr == PTR_LAST);
    assign rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_fir_capture_reader.sv
module tb_fir_capture_reader;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              arm;
  logic              abort;
  logic              trig_en;
  logic [DATA_W-1:0] trig_level;
  logic [1:0]        state;
  logic [ADDR_W:0]   cap_count;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              done;
  logic [DATA_W-1:0] peak_max;
  logic [DATA_W-1:0] peak_min;
  logic [7:0]        drop_cnt;
  logic              arm_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] q[$];

  fir_capture_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .abort(abort), .trig_en(trig_en), .trig_level(trig_level),
    .state(state), .cap_count(cap_count), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .done(done), .peak_max(peak_max),
    .peak_min(peak_min), .drop_cnt(drop_cnt), .arm_err(arm_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok);
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_arm;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v, input bit keep);
    sample_in    = v;
    sample_valid = 1'b1;
    if (keep) q.push_back(v);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int   cyc = 0;
    logic xf;
    rd_ready     = !bp;
    sample_valid = bp;
    sample_in    = 16'h5555;
    while (q.size() > 0 && cyc < 2000) begin
      chk("rd_valid", rd_valid === 1'b1);
      chk("rd_data", rd_data === q[0]);
      chk("rd_last", rd_last === (q.size() == 1));
      xf = rd_ready;
      @(negedge clk);
      cyc++;
      if (xf) void'(q.pop_front());
      if (bp) rd_ready = (cyc >= 270) ? cyc[0] : 1'b0;
    end
    sample_valid = 1'b0;
    rd_ready     = 1'b0;
    chk("drain_timeout", q.size() == 0);
    chk("done_pulse", done === 1'b1);
    chk("drain_exit_state", state === 2'd0);
    chk("drain_exit_rd_valid", rd_valid === 1'b0);
    tick;
    chk("done_clear", done === 1'b0);
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_level = '0;
    sample_in = '0; sample_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
    chk("rst_state", state === 2'd0);
    chk("rst_cap", cap_count === 5'd0);
    chk("rst_rd_valid", rd_valid === 1'b0);
    chk("rst_rd_last", rd_last === 1'b0);
    chk("rst_done", done === 1'b0);
    chk("rst_arm_err", arm_err === 1'b0);
    chk("rst_pmax", peak_max === 16'h0000);
    chk("rst_pmin", peak_min === 16'h0000);
    chk("rst_drop", drop_cnt === 8'd0);

    do_arm;
    chk("arm_state", state === 2'd1);
    chk("arm_cap", cap_count === 5'd0);
    chk("arm_pmax", peak_max === 16'h8000);
    chk("arm_pmin", peak_min === 16'h7FFF);
    for (int unsigned i = 1; i <= 16; i++) begin
      feed(16'(i), 1'b1);
      if (i < 16) begin
        chk("fr_state", state === 2'd2);
        chk("fr_cap", cap_count === 5'(i));
      end
    end
    chk("fr_drain_state", state === 2'd3);
    chk("fr_cap16", cap_count === 5'd16);
    chk("fr_pmax", peak_max === 16'd16);
    chk("fr_pmin", peak_min === 16'd1);
    drain(1'b0);
    chk("fr_drop", drop_cnt === 8'd0);
    chk("fr_hold_cap", cap_count === 5'd16);
    chk("fr_hold_pmax", peak_max === 16'd16);

    trig_en    = 1'b1;
    trig_level = 16'hFFFD;
    do_arm;
    feed(16'hFFF6, 1'b0);
    feed(16'hFFFB, 1'b0);
    chk("lt_wait_state", state === 2'd1);
    chk("lt_wait_cap", cap_count === 5'd0);
    feed(16'hFFFD, 1'b1);
    chk("lt_trig_state", state === 2'd2);
    chk("lt_trig_cap", cap_count === 5'd1);
    tick;
    chk("lt_gap_cap", cap_count === 5'd1);
    for (int unsigned i = 0; i < 15; i++) feed(16'(20 + i), 1'b1);
    chk("lt_drain_state", state === 2'd3);
    chk("lt_pmax", peak_max === 16'd34);
    chk("lt_pmin", peak_min === 16'hFFFD);
    drain(1'b1);
    chk("bp_drop_sat", drop_cnt === 8'd255);
    trig_en = 1'b0;

    do_arm;
    chk("ia_drop_clr", drop_cnt === 8'd0);
    feed(16'd7, 1'b1);
    feed(16'd8, 1'b1);
    arm = 1'b1;
    feed(16'd9, 1'b1);
    arm = 1'b0;
    chk("ia_arm_err", arm_err === 1'b1);
    chk("ia_state", state === 2'd2);
    chk("ia_cap", cap_count === 5'd3);
    feed(16'd10, 1'b1);
    feed(16'd11, 1'b1);
    chk("ab_pre_cap", cap_count === 5'd5);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    q.delete();
    chk("ab_state", state === 2'd0);
    chk("ab_cap", cap_count === 5'd0);
    chk("ab_rd_valid", rd_valid === 1'b0);
    chk("ab_done", done === 1'b0);
    chk("ab_arm_err", arm_err === 1'b1);
    chk("ab_pmax", peak_max === 16'd11);
    chk("ab_pmin", peak_min === 16'd7);
    abort = 1'b1;
    arm   = 1'b1;
    tick;
    abort = 1'b0;
    arm   = 1'b0;
    chk("abarm_state", state === 2'd0);
    chk("abarm_err", arm_err === 1'b1);

    do_arm;
    chk("rearm_err_clr", arm_err === 1'b0);
    chk("rearm_state", state === 2'd1);
    for (int unsigned i = 0; i < 16; i++) feed(16'(100 + i), 1'b1);
    drain(1'b0);
    do_arm;
    for (int unsigned i = 0; i < 16; i++) feed(16'(200 + i), 1'b1);
    chk("b2b_pmax", peak_max === 16'd215);
    chk("b2b_pmin", peak_min === 16'd200);
    drain(1'b0);

    do_arm;
    for (int unsigned i = 0; i < 5; i++) feed(16'(50 + i), 1'b1);
    chk("mr_pre_cap", cap_count === 5'd5);
    chk("mr_pre_state", state === 2'd2);
    #2 rst = 1'b0;
    #1;
    q.delete();
    chk("mr_state", state === 2'd0);
    chk("mr_cap", cap_count === 5'd0);
    chk("mr_rd_valid", rd_valid === 1'b0);
    chk("mr_pmax", peak_max === 16'h0000);
    chk("mr_pmin", peak_min === 16'h0000);
    tick;
    rst = 1'b1;
    tick;
    chk("mr_post_state", state === 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
